// File: rtl/regfile_wb_pkg.sv
// Shared constants for the operand register file and write-back stage:
// ALU function codes and the default addresses of the I/O-mapped registers.
package regfile_wb_pkg;

    // ALU function codes, shared with the ALU decoder.
    typedef enum logic [1:0] {
        RA   = 2'b00,
        RADD = 2'b01,
        RSUB = 2'b10,
        RMUL = 2'b11
    } alu_func_e;

    // Register whose reads return the switch input.
    localparam int unsigned IN_REG_DEF  = 1;
    // Register whose committed value drives the LED output.
    localparam int unsigned OUT_REG_DEF = 2;

    // Pass-through (RA) leaves the architectural Z flag alone.
    function automatic logic func_sets_z(input logic [1:0] f);
        return f != RA;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero register, live switch input, forwarding
// from the pending write-back, then the committed array, in that priority.
module regfile_rdport #(
    parameter int unsigned N      = 8,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter int unsigned IN_REG = 1
) (
    input  logic [AW-1:0] i_addr,
    input  logic [N-1:0]  i_regs [NREGS],
    input  logic          i_wb_valid,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [N-1:0]  i_wb_data,
    input  logic [N-1:0]  i_in_port,
    output logic [N-1:0]  o_rdata
);

    // Priority mux; the in_port check sits above forwarding so a pending
    // write to IN_REG can never shadow the live switches.
    always_comb begin
        o_rdata = '0;
        if (i_addr == AW'(0)) begin
            o_rdata = '0;
        end else if (i_addr == AW'(IN_REG)) begin
            o_rdata = i_in_port;
        end else if (i_wb_valid && (i_wb_addr == i_addr)) begin
            o_rdata = i_wb_data;
        end else begin
            o_rdata = i_regs[i_addr];
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Operand register file with a one-deep write-back register. The ALU result
// is captured on one edge and committed to the array on the next; the read
// ports forward the pending value in between.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned NREGS   = 8,
    parameter int unsigned AW      = $clog2(NREGS),
    parameter int unsigned IN_REG  = IN_REG_DEF,
    parameter int unsigned OUT_REG = OUT_REG_DEF
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          we,
    input  logic          stall,
    input  logic [1:0]    func,
    input  logic [AW-1:0] wa,
    input  logic [N-1:0]  wdata,
    input  logic          zin,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [N-1:0]  in_port,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    output logic          zflag,
    output logic [N-1:0]  out_port
);

    logic [N-1:0]  r_regs [NREGS];
    logic          r_wb_valid;
    logic [AW-1:0] r_wb_addr;
    logic [N-1:0]  r_wb_data;
    logic          r_zflag;
    logic [N-1:0]  r_out;

    logic          w_commit;
    logic          w_commit_out;

    // Writes aimed at the zero register or the switch register are dropped.
    assign w_commit     = r_wb_valid && (r_wb_addr != AW'(0)) && (r_wb_addr != AW'(IN_REG));
    assign w_commit_out = w_commit && (r_wb_addr == AW'(OUT_REG));

    // Write-back capture; stall freezes the pending write so it keeps committing.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else if (!stall) begin
            r_wb_valid <= we;
            r_wb_addr  <= wa;
            r_wb_data  <= wdata;
        end
    end

    // Architectural Z flag, updated at capture by arithmetic functions only.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_zflag <= 1'b0;
        end else if (!stall && we && func_sets_z(func)) begin
            r_zflag <= zin;
        end
    end

    // Commit of the pending write into the array; repeats harmlessly under stall.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[r_wb_addr] <= r_wb_data;
        end
    end

    // LED register mirrors every commit to OUT_REG on the same edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_out <= '0;
        end else if (w_commit_out) begin
            r_out <= r_wb_data;
        end
    end

    regfile_rdport #(
        .N      (N),
        .NREGS  (NREGS),
        .AW     (AW),
        .IN_REG (IN_REG)
    ) u_rdport1 (
        .i_addr     (ra1),
        .i_regs     (r_regs),
        .i_wb_valid (r_wb_valid),
        .i_wb_addr  (r_wb_addr),
        .i_wb_data  (r_wb_data),
        .i_in_port  (in_port),
        .o_rdata    (rd1)
    );

    regfile_rdport #(
        .N      (N),
        .NREGS  (NREGS),
        .AW     (AW),
        .IN_REG (IN_REG)
    ) u_rdport2 (
        .i_addr     (ra2),
        .i_regs     (r_regs),
        .i_wb_valid (r_wb_valid),
        .i_wb_addr  (r_wb_addr),
        .i_wb_data  (r_wb_data),
        .i_in_port  (in_port),
        .o_rdata    (rd2)
    );

    assign zflag    = r_zflag;
    assign out_port = r_out;

endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed vector table, hand-written stall/reset
// sequences, then randomized traffic against a reference model.
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    localparam int unsigned NV = 14;

    logic       clk;
    logic       n_reset;
    logic       we;
    logic       stall;
    logic [1:0] func;
    logic [2:0] wa;
    logic [7:0] wdata;
    logic       zin;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] in_port;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       zflag;
    logic [7:0] out_port;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb #(
        .N     (8),
        .NREGS (8)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .we       (we),
        .stall    (stall),
        .func     (func),
        .wa       (wa),
        .wdata    (wdata),
        .zin      (zin),
        .ra1      (ra1),
        .ra2      (ra2),
        .in_port  (in_port),
        .rd1      (rd1),
        .rd2      (rd2),
        .zflag    (zflag),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic       stall;
        logic [1:0] func;
        logic [2:0] wa;
        logic [7:0] wdata;
        logic       zin;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic [7:0] in_port;
        logic [7:0] e_rd1;
        logic [7:0] e_rd2;
        logic       e_z;
        logic [7:0] e_out;
    } vec_t;

    vec_t vecs [NV];

    // Reference state: committed contents plus one pending write.
    logic [7:0] m_reg [8];
    logic       m_wbv;
    logic [2:0] m_wba;
    logic [7:0] m_wbd;
    logic       m_z;
    logic [7:0] m_out;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] a);
        if (a == 3'd0) return 8'h00;
        if (a == 3'd1) return in_port;
        if (m_wbv && m_wba == a) return m_wbd;
        return m_reg[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_wbv = 1'b0;
        m_wba = 3'd0;
        m_wbd = 8'h00;
        m_z   = 1'b0;
        m_out = 8'h00;
    endtask

    // One rising edge: old pending write lands, then new capture.
    task automatic m_step();
        if (m_wbv && m_wba != 3'd0 && m_wba != 3'd1) begin
            m_reg[m_wba] = m_wbd;
            if (m_wba == 3'd2) m_out = m_wbd;
        end
        if (!stall) begin
            m_wbv = we;
            m_wba = wa;
            m_wbd = wdata;
            if (we && func != RA) m_z = zin;
        end
    endtask

    task automatic apply(input vec_t v);
        we      = v.we;
        stall   = v.stall;
        func    = v.func;
        wa      = v.wa;
        wdata   = v.wdata;
        zin     = v.zin;
        ra1     = v.ra1;
        ra2     = v.ra2;
        in_port = v.in_port;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // we st func wa wdata zin ra1 ra2 in | rd1 rd2 z out
        vecs[0]  = '{1'b1, 1'b0, RADD, 3'd3, 8'h40, 1'b0, 3'd3, 3'd0, 8'h00, 8'h40, 8'h00, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, RA,   3'd0, 8'h00, 1'b0, 3'd3, 3'd3, 8'h00, 8'h40, 8'h40, 1'b0, 8'h00};
        vecs[2]  = '{1'b1, 1'b0, RSUB, 3'd5, 8'h10, 1'b1, 3'd3, 3'd5, 8'h00, 8'h40, 8'h10, 1'b1, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, RA,   3'd6, 8'h20, 1'b0, 3'd5, 3'd6, 8'h00, 8'h10, 8'h20, 1'b1, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, RMUL, 3'd7, 8'h30, 1'b0, 3'd6, 3'd7, 8'h00, 8'h20, 8'h30, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 1'b0, RA,   3'd0, 8'hFF, 1'b0, 3'd0, 3'd7, 8'h00, 8'h00, 8'h30, 1'b0, 8'h00};
        vecs[6]  = '{1'b0, 1'b0, RA,   3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 8'h5A, 8'h00, 8'h00, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, RA,   3'd1, 8'hFF, 1'b0, 3'd1, 3'd1, 8'h5A, 8'h5A, 8'h5A, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, RA,   3'd0, 8'h00, 1'b0, 3'd1, 3'd0, 8'hA5, 8'hA5, 8'h00, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, RA,   3'd2, 8'h81, 1'b0, 3'd3, 3'd2, 8'h00, 8'h40, 8'h81, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b0, RA,   3'd0, 8'h00, 1'b0, 3'd2, 3'd2, 8'h00, 8'h81, 8'h81, 1'b0, 8'h81};
        vecs[11] = '{1'b1, 1'b0, RA,   3'd4, 8'h11, 1'b0, 3'd4, 3'd2, 8'h00, 8'h11, 8'h81, 1'b0, 8'h81};
        vecs[12] = '{1'b1, 1'b0, RA,   3'd4, 8'h22, 1'b0, 3'd4, 3'd4, 8'h00, 8'h22, 8'h22, 1'b0, 8'h81};
        vecs[13] = '{1'b0, 1'b0, RA,   3'd0, 8'h00, 1'b0, 3'd4, 3'd4, 8'h00, 8'h22, 8'h22, 1'b0, 8'h81};

        n_reset = 1'b0;
        we = 1'b0; stall = 1'b0; func = RA; wa = 3'd0; wdata = 8'h00; zin = 1'b0;
        ra1 = 3'd3; ra2 = 3'd2; in_port = 8'h00;
        #2;
        check("reset_rd1", rd1, 8'h00);
        check("reset_rd2", rd2, 8'h00);
        check("reset_z", {7'b0, zflag}, 8'h00);
        check("reset_out", out_port, 8'h00);
        #10 n_reset = 1'b1;

        // Directed table: outputs sampled just after the edge that consumed the vector.
        for (int i = 0; i < int'(NV); i++) begin
            apply(vecs[i]);
            tick();
            check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e_rd1);
            check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e_rd2);
            check($sformatf("vec%0d_z", i), {7'b0, zflag}, {7'b0, vecs[i].e_z});
            check($sformatf("vec%0d_out", i), out_port, vecs[i].e_out);
        end

        // Asynchronous reset mid-cycle with a pending write and Z set.
        we = 1'b1; wa = 3'd5; wdata = 8'h33; func = RSUB; zin = 1'b1; ra1 = 3'd3; ra2 = 3'd2;
        tick();
        check("pre_reset_z", {7'b0, zflag}, 8'h01);
        check("pre_reset_rd2", rd2, 8'h81);
        #2 n_reset = 1'b0;
        #1;
        check("async_rd1", rd1, 8'h00);
        check("async_rd2", rd2, 8'h00);
        check("async_z", {7'b0, zflag}, 8'h00);
        check("async_out", out_port, 8'h00);
        we = 1'b0;
        #2 n_reset = 1'b1;
        tick();
        ra2 = 3'd5;
        #1 check("reset_dropped_wb", rd2, 8'h00);

        // Stall holds the captured write; Z must not move while stalled.
        we = 1'b1; wa = 3'd4; wdata = 8'h11; func = RADD; zin = 1'b1; stall = 1'b0; ra1 = 3'd4;
        tick();
        check("stall_cap_rd1", rd1, 8'h11);
        check("stall_cap_z", {7'b0, zflag}, 8'h01);
        stall = 1'b1; wdata = 8'h22; func = RMUL; zin = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d_rd1", c), rd1, 8'h11);
            check($sformatf("stall%0d_z", c), {7'b0, zflag}, 8'h01);
        end
        #2 n_reset = 1'b0;
        #1 check("stall_reset_rd1", rd1, 8'h00);
        #2 n_reset = 1'b1;
        stall = 1'b0; we = 1'b0;
        tick();
        check("after_reset_reg4", rd1, 8'h00);
        check("after_reset_z", {7'b0, zflag}, 8'h00);

        // Randomized traffic against the reference model.
        #2 n_reset = 1'b0;
        m_reset();
        #2 n_reset = 1'b1;
        tick();
        for (int c = 0; c < 400; c++) begin
            we      = 1'($urandom_range(1));
            stall   = ($urandom_range(3) == 0);
            func    = 2'($urandom_range(3));
            wa      = 3'($urandom_range(7));
            wdata   = 8'($urandom);
            zin     = 1'($urandom_range(1));
            ra1     = 3'($urandom_range(7));
            ra2     = 3'($urandom_range(7));
            in_port = 8'($urandom);
            #1;
            check("rnd_rd1", rd1, m_read(ra1));
            check("rnd_rd2", rd2, m_read(ra2));
            check("rnd_z", {7'b0, zflag}, {7'b0, m_z});
            check("rnd_out", out_port, m_out);
            m_step();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
